// File: rtl/mod_counter_pkg.sv
// Shared encodings and sizing helpers for the modulo-N counter family.
package mod_counter_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// Enable prescaler: issues one tick every PRESCALE enabled cycles, holding phase while idle.
module tick_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sync_clr,
  output logic tick
);

  // At least one bit so PRESCALE=1 still elaborates; the count then stays at 0.
  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE must be >= 1");
    end
  endgenerate

  logic [PW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with load/clear, wrap or saturate, and overflow status.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  generate
    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
      $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic step;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .sync_clr(clear | load),
    .tick    (step)
  );

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] step_out;
  logic             step_wrap;
  logic             hit_bound;
  logic [WIDTH-1:0] load_out;

  assign at_top = (out == TOP);
  assign at_bot = (out == '0);
  assign tc     = (up == DIR_UP) ? at_top : at_bot;

  // Out-of-range loads clamp to the top of the count range.
  assign load_out = ({1'b0, load_val} >= (WIDTH + 1)'(MODULUS)) ? TOP : load_val;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    step_out  = out;
    step_wrap = 1'b0;
    hit_bound = 1'b0;
    if (step) begin
      if (up == DIR_UP) begin
        if (at_top) begin
          hit_bound = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            step_out  = '0;
            step_wrap = 1'b1;
          end
        end else begin
          step_out = out + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          hit_bound = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            step_out  = TOP;
            step_wrap = 1'b1;
          end
        end else begin
          step_out = out - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      out  <= load_out;
      wrap <= 1'b0;
    end else begin
      out  <= step_out;
      wrap <= step_wrap;
    end
  end

  // A bound hit only counts when the step actually takes effect (no clear/load that cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky <= 1'b0;
    end else if (hit_bound && !clear && !load) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
